// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the data-memory responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for an AXI burst (FIXED / INCR / WRAP).
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [1:0]        shift;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  // Wider-than-lane sizes are clamped to 8 bytes; illegal wrap lengths fall back to INCR.
  always_comb begin
    shift     = (size > 3'd3) ? 2'd3 : size[1:0];
    step      = ADDR_W'(1) << shift;
    incr_addr = addr + step;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << shift) - ADDR_W'(1);
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if (burst == BURST_WRAP && wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/dmem_axi_slave.sv
// AXI4 responder for the core's data port, backed by a 64-bit-wide dual-ported memory.
module dmem_axi_slave
  import axi_pkg::*;
#(
  parameter int MEM_BYTES = 65536,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Dawaddr,
  input  logic [1:0]        Dawburst,
  input  logic [3:0]        Dawcache,
  input  logic [7:0]        Dawlen,
  input  logic [2:0]        Dawsize,
  input  logic              Dawvalid,
  output logic              Dawready,
  input  logic [63:0]       Dwdata,
  input  logic [7:0]        Dwstrb,
  input  logic              Dwlast,
  input  logic              Dwvalid,
  output logic              Dwready,
  output logic [1:0]        Dbresp,
  output logic              Dbvalid,
  input  logic              Dbready,
  input  logic [ADDR_W-1:0] Daraddr,
  input  logic [1:0]        Darburst,
  input  logic [3:0]        Darcache,
  input  logic [7:0]        Darlen,
  input  logic [2:0]        Darsize,
  input  logic              Darvalid,
  output logic              Darready,
  output logic [63:0]       Drdata,
  output logic              Drlast,
  output logic              Drvalid,
  input  logic              Drready
);

  localparam int WORDS = MEM_BYTES / 8;
  localparam int IDX_W = $clog2(WORDS);

  logic [63:0] mem [WORDS];

  logic unused_cache;
  assign unused_cache = ^{Dawcache, Darcache};

  // ---------------- write side ----------------
  wr_state_e         wstate_q, wstate_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, waddr_nxt;
  logic [7:0]        wlen_q, wlen_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic [8:0]        wcnt_q, wcnt_d;
  logic              werr_q, werr_d;
  logic              w_beat, w_in_burst, w_in_range, w_we;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_waddr (
    .addr(waddr_q), .len(wlen_q), .size(wsize_q), .burst(wburst_q), .next_addr(waddr_nxt)
  );

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) wstate_q <= W_IDLE;
    else     wstate_q <= wstate_d;
  end

  // Write FSM next state: the burst always ends on Dwlast, whatever the beat count.
  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (Dawvalid) wstate_d = W_DATA;
      W_DATA:  if (Dwvalid && Dwlast) wstate_d = W_RESP;
      W_RESP:  if (Dbready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Write FSM outputs.
  always_comb begin
    Dawready = (wstate_q == W_IDLE);
    Dwready  = (wstate_q == W_DATA);
    Dbvalid  = (wstate_q == W_RESP);
    Dbresp   = (Dbvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  end

  // Write datapath: latch AW, advance address per beat, accumulate the error flag.
  always_comb begin
    w_beat     = (wstate_q == W_DATA) && Dwvalid;
    w_in_burst = (wcnt_q <= {1'b0, wlen_q});
    w_in_range = (waddr_q < ADDR_W'(MEM_BYTES));
    w_we       = w_beat && w_in_burst && w_in_range && !rst;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    if (wstate_q == W_IDLE && Dawvalid) begin
      waddr_d  = Dawaddr;
      wlen_d   = Dawlen;
      wsize_d  = Dawsize;
      wburst_d = Dawburst;
      wcnt_d   = 9'd0;
      werr_d   = 1'b0;
    end else if (w_beat) begin
      waddr_d = waddr_nxt;
      if (w_in_burst) wcnt_d = wcnt_q + 9'd1;
      if (!w_in_burst || !w_in_range || (Dwlast && wcnt_q != {1'b0, wlen_q})) werr_d = 1'b1;
    end
  end

  // Write datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (Dwstrb[b]) mem[waddr_q[IDX_W+2:3]][8*b +: 8] <= Dwdata[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_e         rstate_q, rstate_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, raddr_nxt, rd_addr;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              rlast_q, rlast_d, r_fetch;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_raddr (
    .addr(raddr_q), .len(rlen_q), .size(rsize_q), .burst(rburst_q), .next_addr(raddr_nxt)
  );

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rstate_q <= R_IDLE;
    else     rstate_q <= rstate_d;
  end

  // Read FSM next state: leave DATA once the beat flagged last is taken.
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (Darvalid) rstate_d = R_DATA;
      R_DATA:  if (Drready && rlast_q) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; data and last come straight from registers so they hold during stalls.
  always_comb begin
    Darready = (rstate_q == R_IDLE);
    Drvalid  = (rstate_q == R_DATA);
    Drlast   = Drvalid && rlast_q;
    Drdata   = rdata_q;
  end

  // Read datapath: fetch beat 0 on AR acceptance, then the next beat after each handshake.
  always_comb begin
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rlast_d  = rlast_q;
    rdata_d  = rdata_q;
    rd_addr  = raddr_nxt;
    r_fetch  = 1'b0;
    if (rstate_q == R_IDLE && Darvalid) begin
      raddr_d  = Daraddr;
      rlen_d   = Darlen;
      rsize_d  = Darsize;
      rburst_d = Darburst;
      rcnt_d   = 8'd0;
      rlast_d  = (Darlen == 8'd0);
      rd_addr  = Daraddr;
      r_fetch  = 1'b1;
    end else if (rstate_q == R_DATA && Drready && !rlast_q) begin
      raddr_d = raddr_nxt;
      rcnt_d  = rcnt_q + 8'd1;
      rlast_d = ((rcnt_q + 8'd1) == rlen_q);
      r_fetch = 1'b1;
    end
    if (r_fetch) begin
      rdata_d = (rd_addr < ADDR_W'(MEM_BYTES)) ? mem[rd_addr[IDX_W+2:3]] : 64'd0;
    end
  end

  // Read datapath registers; the data register is the memory's registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rlast_q  <= rlast_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_axi_slave.sv
// Self-checking bench for dmem_axi_slave against a byte-array memory model.
module tb_dmem_axi_slave;

  localparam int MEM_BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Dawaddr, Daraddr;
  logic [1:0]  Dawburst, Darburst, Dbresp;
  logic [3:0]  Dawcache, Darcache;
  logic [7:0]  Dawlen, Darlen, Dwstrb;
  logic [2:0]  Dawsize, Darsize;
  logic        Dawvalid, Dawready, Dwlast, Dwvalid, Dwready, Dbvalid, Dbready;
  logic        Darvalid, Darready, Drlast, Drvalid, Drready;
  logic [63:0] Dwdata, Drdata;

  dmem_axi_slave #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .Dawaddr(Dawaddr), .Dawburst(Dawburst), .Dawcache(Dawcache), .Dawlen(Dawlen),
    .Dawsize(Dawsize), .Dawvalid(Dawvalid), .Dawready(Dawready),
    .Dwdata(Dwdata), .Dwstrb(Dwstrb), .Dwlast(Dwlast), .Dwvalid(Dwvalid), .Dwready(Dwready),
    .Dbresp(Dbresp), .Dbvalid(Dbvalid), .Dbready(Dbready),
    .Daraddr(Daraddr), .Darburst(Darburst), .Darcache(Darcache), .Darlen(Darlen),
    .Darsize(Darsize), .Darvalid(Darvalid), .Darready(Darready),
    .Drdata(Drdata), .Drlast(Drlast), .Drvalid(Drvalid), .Drready(Drready)
  );

  always #5 clk = ~clk;

  int          nCompared   = 0;
  int          nMismatched = 0;
  logic [7:0]  mdl  [MEM_BYTES];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];

  // Safety net so a hung handshake can never stall the run.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%016h expected=0x%016h", tag, observed, expected);
    end
  endtask

  // Address of beat n of a burst, from the AXI burst rules.
  function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst, input int n);
    logic [31:0] step, win, base;
    int sh;
    sh   = (size > 3'd3) ? 3 : int'(size);
    step = 32'd1 << sh;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      win  = (32'(len) + 32'd1) * step;
      base = start - (start % win);
      return base + (((start - base) + 32'(n) * step) % win);
    end
    return start + 32'(n) * step;
  endfunction

  function automatic logic [63:0] modelWord(input logic [31:0] a);
    logic [63:0] w;
    w = 64'd0;
    if (a < 32'(MEM_BYTES)) begin
      for (int b = 0; b < 8; b++) w[8*b +: 8] = mdl[int'({a[31:3], 3'b000}) + b];
    end
    return w;
  endfunction

  // One complete AW/W/B write transaction; beat data comes from wbuf/sbuf, Dwlast on beat nBeats-1.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int nBeats, input string tag);
    logic        err;
    logic [31:0] a;
    int          w;
    err = 1'b0;
    Dawaddr = addr; Dawlen = len; Dawsize = size; Dawburst = burst; Dawvalid = 1'b1;
    w = 0;
    while (Dawready !== 1'b1 && w < 20) begin @(posedge clk); @(negedge clk); w++; end
    checkOutput({tag, "/awready"}, 64'(Dawready), 64'd1);
    @(posedge clk); @(negedge clk);
    Dawvalid = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      Dwdata = wbuf[i]; Dwstrb = sbuf[i]; Dwlast = (i == nBeats - 1); Dwvalid = 1'b1;
      w = 0;
      while (Dwready !== 1'b1 && w < 20) begin @(posedge clk); @(negedge clk); w++; end
      checkOutput({tag, "/wready"}, 64'(Dwready), 64'd1);
      a = beatAddr(addr, len, size, burst, i);
      if (i > int'(len)) err = 1'b1;
      else if (a >= 32'(MEM_BYTES)) err = 1'b1;
      else begin
        for (int b = 0; b < 8; b++)
          if (sbuf[i][b]) mdl[int'({a[31:3], 3'b000}) + b] = wbuf[i][8*b +: 8];
      end
      @(posedge clk); @(negedge clk);
    end
    if (nBeats != int'(len) + 1) err = 1'b1;
    Dwvalid = 1'b0; Dwlast = 1'b0; Dbready = 1'b1;
    w = 0;
    while (Dbvalid !== 1'b1 && w < 20) begin @(posedge clk); @(negedge clk); w++; end
    checkOutput({tag, "/bvalid"}, 64'(Dbvalid), 64'd1);
    checkOutput({tag, "/bresp"}, 64'(Dbresp), err ? 64'd2 : 64'd0);
    @(posedge clk); @(negedge clk);
    Dbready = 1'b0;
    checkOutput({tag, "/bdone"}, 64'(Dbvalid), 64'd0);
  endtask

  // One AR/R read burst; mode 0 = always ready, 1 = ready 1,0,1,0..., 2 = random ready.
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode, input string tag);
    int   i, cyc, stalls, w;
    logic rdy;
    Daraddr = addr; Darlen = len; Darsize = size; Darburst = burst; Darvalid = 1'b1; Drready = 1'b0;
    w = 0;
    while (Darready !== 1'b1 && w < 20) begin @(posedge clk); @(negedge clk); w++; end
    checkOutput({tag, "/arready"}, 64'(Darready), 64'd1);
    @(posedge clk); @(negedge clk);
    Darvalid = 1'b0;
    i = 0; cyc = 0; stalls = 0;
    while (i <= int'(len) && cyc < 2000) begin
      checkOutput({tag, "/rvalid"}, 64'(Drvalid), 64'd1);
      checkOutput({tag, "/rdata"}, Drdata, modelWord(beatAddr(addr, len, size, burst, i)));
      checkOutput({tag, "/rlast"}, 64'(Drlast), 64'(i == int'(len)));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      stalls  = rdy ? 0 : stalls + 1;
      Drready = rdy;
      @(posedge clk); @(negedge clk);
      if (rdy) i++;
      cyc++;
    end
    Drready = 1'b0;
    checkOutput({tag, "/rdone"}, 64'(Drvalid), 64'd0);
    checkOutput({tag, "/arready_idle"}, 64'(Darready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    logic [63:0] oldA;

    for (int k = 0; k < MEM_BYTES; k++) mdl[k] = 8'h00;
    rst = 1'b1;
    Dawaddr = '0; Dawburst = '0; Dawcache = '0; Dawlen = '0; Dawsize = '0; Dawvalid = 1'b0;
    Dwdata = '0; Dwstrb = '0; Dwlast = 1'b0; Dwvalid = 1'b0; Dbready = 1'b0;
    Daraddr = '0; Darburst = '0; Darcache = '0; Darlen = '0; Darsize = '0; Darvalid = 1'b0;
    Drready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst/awready", 64'(Dawready), 64'd1);
    checkOutput("rst/arready", 64'(Darready), 64'd1);
    checkOutput("rst/wready", 64'(Dwready), 64'd0);
    checkOutput("rst/bvalid", 64'(Dbvalid), 64'd0);
    checkOutput("rst/bresp", 64'(Dbresp), 64'd0);
    checkOutput("rst/rvalid", 64'(Drvalid), 64'd0);
    checkOutput("rst/rlast", 64'(Drlast), 64'd0);
    checkOutput("rst/rdata", Drdata, 64'd0);
    rst = 1'b0;

    $display("[TB] zero-filling 0x0000-0x1FFF");
    for (int k = 0; k < 256; k++) begin wbuf[k] = 64'd0; sbuf[k] = 8'hFF; end
    for (int f = 0; f < 4; f++) applyStimulus(32'(f * 2048), 8'd255, 3'd3, 2'b01, 256, "fill");

    $display("[TB] single beat write/read");
    wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
    applyStimulus(32'h100, 8'd0, 3'd3, 2'b01, 1, "single_wr");
    readBurst(32'h100, 8'd0, 3'd3, 2'b01, 0, "single_rd");

    $display("[TB] INCR burst with Drready toggling");
    for (int k = 0; k < 4; k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'hFF; end
    applyStimulus(32'h200, 8'd3, 3'd3, 2'b01, 4, "incr_wr");
    readBurst(32'h200, 8'd3, 3'd3, 2'b01, 1, "incr_rd");

    $display("[TB] WRAP read");
    for (int k = 0; k < 4; k++) begin wbuf[k] = 64'hA0A0_0000_0000_0000 + 64'(k); sbuf[k] = 8'hFF; end
    applyStimulus(32'h300, 8'd3, 3'd3, 2'b01, 4, "wrap_fill");
    readBurst(32'h318, 8'd3, 3'd3, 2'b10, 0, "wrap_rd");

    $display("[TB] byte strobes");
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'h0F;
    applyStimulus(32'h500, 8'd0, 3'd3, 2'b01, 1, "strb_wr");
    readBurst(32'h500, 8'd0, 3'd3, 2'b01, 0, "strb_rd");

    $display("[TB] error responses");
    wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF; sbuf[0] = 8'hFF;
    applyStimulus(32'(MEM_BYTES), 8'd0, 3'd3, 2'b01, 1, "oob_wr");
    readBurst(32'h0, 8'd0, 3'd3, 2'b01, 0, "alias_rd");
    readBurst(32'(MEM_BYTES), 8'd0, 3'd3, 2'b01, 0, "oob_rd");
    wbuf[0] = 64'h0101; wbuf[1] = 64'h0202; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    applyStimulus(32'h600, 8'd3, 3'd3, 2'b01, 2, "short_wr");
    readBurst(32'h600, 8'd3, 3'd3, 2'b01, 0, "short_rd");
    wbuf[0] = 64'h0303; wbuf[1] = 64'h0404; wbuf[2] = 64'h0505; sbuf[2] = 8'hFF;
    applyStimulus(32'h700, 8'd0, 3'd3, 2'b01, 3, "long_wr");
    readBurst(32'h700, 8'd1, 3'd3, 2'b01, 0, "long_rd");

    $display("[TB] reset during read burst");
    Daraddr = 32'h200; Darlen = 8'd3; Darsize = 3'd3; Darburst = 2'b01; Darvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    Darvalid = 1'b0;
    checkOutput("rstrd/beat0", Drdata, modelWord(32'h200));
    Drready = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("rstrd/beat1", Drdata, modelWord(32'h208));
    Drready = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checkOutput("rstrd/rvalid", 64'(Drvalid), 64'd0);
    checkOutput("rstrd/arready", 64'(Darready), 64'd1);
    checkOutput("rstrd/rdata", Drdata, 64'd0);
    readBurst(32'h200, 8'd3, 3'd3, 2'b01, 0, "post_rst_rd");

    $display("[TB] read and write to the same word in one cycle");
    oldA = modelWord(32'h400);
    Dawaddr = 32'h400; Dawlen = 8'd0; Dawsize = 3'd3; Dawburst = 2'b01; Dawvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    Dawvalid = 1'b0;
    Dwdata = 64'hCAFE_F00D_1234_5678; Dwstrb = 8'hFF; Dwlast = 1'b1; Dwvalid = 1'b1;
    Daraddr = 32'h400; Darlen = 8'd0; Darsize = 3'd3; Darburst = 2'b01; Darvalid = 1'b1;
    checkOutput("rdw/wready", 64'(Dwready), 64'd1);
    checkOutput("rdw/arready", 64'(Darready), 64'd1);
    @(posedge clk); @(negedge clk);
    Dwvalid = 1'b0; Dwlast = 1'b0; Darvalid = 1'b0;
    for (int b = 0; b < 8; b++) mdl[32'h400 + b] = Dwdata[8*b +: 8];
    checkOutput("rdw/rvalid", 64'(Drvalid), 64'd1);
    checkOutput("rdw/old_data", Drdata, oldA);
    checkOutput("rdw/bresp", 64'(Dbresp), 64'd0);
    Drready = 1'b1; Dbready = 1'b1;
    @(posedge clk); @(negedge clk);
    Drready = 1'b0; Dbready = 1'b0;
    readBurst(32'h400, 8'd0, 3'd3, 2'b01, 0, "rdw_new");

    $display("[TB] simultaneous AW and AR");
    Dawaddr = 32'h408; Dawlen = 8'd0; Dawsize = 3'd3; Dawburst = 2'b01; Dawvalid = 1'b1;
    Daraddr = 32'h400; Darlen = 8'd0; Darsize = 3'd3; Darburst = 2'b01; Darvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    Dawvalid = 1'b0; Darvalid = 1'b0;
    checkOutput("both/wready", 64'(Dwready), 64'd1);
    checkOutput("both/rvalid", 64'(Drvalid), 64'd1);
    checkOutput("both/rdata", Drdata, modelWord(32'h400));
    Drready = 1'b1;
    Dwdata = 64'h0BAD_C0DE_0BAD_C0DE; Dwstrb = 8'hFF; Dwlast = 1'b1; Dwvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    Drready = 1'b0; Dwvalid = 1'b0; Dwlast = 1'b0;
    for (int b = 0; b < 8; b++) mdl[32'h408 + b] = Dwdata[8*b +: 8];
    checkOutput("both/bvalid", 64'(Dbvalid), 64'd1);
    checkOutput("both/rdone", 64'(Drvalid), 64'd0);
    Dbready = 1'b1;
    @(posedge clk); @(negedge clk);
    Dbready = 1'b0;
    readBurst(32'h408, 8'd0, 3'd3, 2'b01, 0, "both_rd");

    $display("[TB] randomized bursts");
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 5))
        0:       rl = 8'd0;
        1:       rl = 8'd1;
        2:       rl = 8'd3;
        3:       rl = 8'd7;
        4:       rl = 8'd15;
        default: rl = 8'($urandom_range(0, 12));
      endcase
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 7));
      ra = 32'h1000 + 32'($urandom_range(0, 32'hDFF));
      for (int k = 0; k <= int'(rl); k++) begin wbuf[k] = {$urandom, $urandom}; sbuf[k] = 8'($urandom); end
      applyStimulus(ra, rl, rs, rb, int'(rl) + 1, "rnd_wr");
      readBurst(ra, rl, rs, rb, 2, "rnd_rd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
